sync_fifo_pf: RTL

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, fill count, synchronous flush and sticky overflow/underflow error flags. It is the same-clock-domain counterpart of the team's asynchronous FIFO, used wherever producer and consumer share a clock but need watermark-based flow control. First-word-fall-through read mode is selectable at compile time.

---
 rtl/sync_fifo_pf.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_pf.sv
// rtl/sync_fifo_pf.sv - single-clock FIFO with watermarks, fill count, flush and sticky error flags
// Define FIFO_FWFT_EN for first-word-fall-through reads through a prefetch register.
module sync_fifo_pf #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          fifo_clk,
  input  logic                          fifo_rst_n,
  input  logic                          fifo_clr,
  input  logic                          fifo_wen,
  input  logic [FIFO_WIDTH-1:0]         fifo_wdata,
  output logic                          fifo_full,
  output logic                          fifo_afull,
  input  logic                          fifo_ren,
  output logic [FIFO_WIDTH-1:0]         fifo_rdata,
  output logic                          fifo_empty,
  output logic                          fifo_aempty,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_afull_thr,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_aempty_thr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_ovf,
  output logic                          fifo_udf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          afull_q;
  logic          aempty_q;
  logic          ovf_q;
  logic          udf_q;
  logic          empty_w;
  logic          wr_acc;
  logic          rd_acc;

  // Flush wins over both requests; acceptance looks at this cycle's registered flags.
  assign wr_acc = fifo_wen && !full_q && !fifo_clr;
  assign rd_acc = fifo_ren && !empty_w && !fifo_clr;

  always_comb begin
    count_nxt = count_q;
    if (wr_acc && !rd_acc) begin
      count_nxt = count_q + CNT_ONE;
    end else if (!wr_acc && rd_acc) begin
      count_nxt = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge fifo_clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= fifo_wdata;
    end
  end

  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wr_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else if (fifo_clr) begin
      wr_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= (fifo_afull_thr == '0);
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      count_q  <= count_nxt;
      full_q   <= (count_nxt == DEPTH_C);
      afull_q  <= (count_nxt >= fifo_afull_thr);
      aempty_q <= (count_nxt <= fifo_aempty_thr);
      if (fifo_wen && full_q) begin
        ovf_q <= 1'b1;
      end
      if (fifo_ren && empty_w) begin
        udf_q <= 1'b1;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  logic [FIFO_WIDTH-1:0] head_q;
  logic                  head_valid_q;
  logic [CW-1:0]         mem_cnt;
  logic                  pf_load;

  // Memory holds everything behind the head word; refill the head when it is free or popped.
  assign mem_cnt = count_q - CW'(head_valid_q);
  assign pf_load = (mem_cnt != '0) && (!head_valid_q || rd_acc);
  assign empty_w = !head_valid_q;

  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      rd_ptr       <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else if (fifo_clr) begin
      rd_ptr       <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else if (pf_load) begin
      head_q       <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + PTR_ONE;
      head_valid_q <= 1'b1;
    end else if (rd_acc) begin
      head_valid_q <= 1'b0;
    end
  end

  assign fifo_rdata = head_q;
`else
  logic [FIFO_WIDTH-1:0] rdata_q;
  logic                  empty_q;

  assign empty_w = empty_q;

  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      rd_ptr  <= '0;
      rdata_q <= '0;
      empty_q <= 1'b1;
    end else if (fifo_clr) begin
      rd_ptr  <= '0;
      rdata_q <= '0;
      empty_q <= 1'b1;
    end else begin
      if (rd_acc) begin
        rdata_q <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      empty_q <= (count_nxt == '0);
    end
  end

  assign fifo_rdata = rdata_q;
`endif

  assign fifo_full   = full_q;
  assign fifo_afull  = afull_q;
  assign fifo_empty  = empty_w;
  assign fifo_aempty = aempty_q;
  assign fifo_count  = count_q;
  assign fifo_ovf    = ovf_q;
  assign fifo_udf    = udf_q;

endmodule
